// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared types and constants for the EX-stage multiply/divide unit:
//            operation encoding, FSM state encoding and datapath widths.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Signed variants work on magnitudes and correct the sign at the end.
  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_if
// Brief    : EX-stage request / result bundle between the pipeline (master)
//            and the multiply/divide unit (slave).
// Revision : 1.0
// ============================================================================
interface ex_muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             start_E;
  md_op_t           md_op_E;
  logic [WIDTH-1:0] rs_data_E;
  logic [WIDTH-1:0] rt_data_E;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_E, md_op_E, rs_data_E, rt_data_E, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start_E, md_op_E, rs_data_E, rt_data_E, flush,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : md_sign_fix
// Brief    : Conditional two's-complement negate. Takes magnitudes of signed
//            operands at capture and restores result signs in FIX.
// Revision : 1.0
// ============================================================================
module md_sign_fix #(
  parameter int W = 32
) (
  input  wire logic [W-1:0] value,
  input  wire logic         negate,
  output logic      [W-1:0] result
);
  assign result = negate ? ((~value) + W'(1)) : value;
endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO; owns HI/LO.
//            Shift-add multiply and restoring divide, one bit per cycle on
//            magnitudes, sign correction in a final FIX cycle.
//            Build macro FAST_MULT_EN: single-cycle combinational multiply.
// Revision : 1.0
// ============================================================================
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  ex_muldiv_unit_if.slave bus
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
  logic                 neg_res;   // product / quotient needs negation
  logic                 neg_rem;   // remainder takes the dividend's sign
  logic                 div_zero;
  logic                 is_div;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  logic                 start_ok;
  logic                 op_signed;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  // A flush in the same cycle as start_E kills the request before it starts.
  assign start_ok  = bus.start_E && !bus.flush;
  assign op_signed = md_is_signed(bus.md_op_E);

  md_sign_fix #(.W(WIDTH)) u_mag_a (
    .value(bus.rs_data_E), .negate(op_signed & bus.rs_data_E[WIDTH-1]), .result(mag_a));
  md_sign_fix #(.W(WIDTH)) u_mag_b (
    .value(bus.rt_data_E), .negate(op_signed & bus.rt_data_E[WIDTH-1]), .result(mag_b));

  // Shift-add step: add multiplicand when multiplier LSB is set, shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Restoring step: shifted remainder needs one extra bit before the compare.
  // When the subtract is kept the true difference is below the divisor, so
  // the low WIDTH bits of the difference are exact.
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge   = rem_sh >= {1'b0, opnd};
  assign div_diff = rem_sh[WIDTH-1:0] - opnd;
  assign div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .value(acc), .negate(neg_res), .result(prod_fix));
  md_sign_fix #(.W(WIDTH)) u_fix_quot (
    .value(acc[WIDTH-1:0]), .negate(neg_res), .result(quot_fix));
  md_sign_fix #(.W(WIDTH)) u_fix_rem (
    .value(acc[2*WIDTH-1:WIDTH]), .negate(neg_rem), .result(rem_fix));

`ifdef FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Sign-extending both operands to 2*WIDTH makes one multiplier serve both
  // the signed and unsigned flavours.
  assign fast_prod = {{WIDTH{op_signed & bus.rs_data_E[WIDTH-1]}}, bus.rs_data_E}
                   * {{WIDTH{op_signed & bus.rt_data_E[WIDTH-1]}}, bus.rt_data_E};
`endif

  // Control FSM, iteration datapath and HI/LO architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      done_r <= 1'b0;
      if (state != IDLE && bus.flush) begin
        state  <= IDLE;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              case (bus.md_op_E)
                MD_MTHI: hi_r <= bus.rs_data_E;
                MD_MTLO: lo_r <= bus.rs_data_E;
                MD_MULT, MD_MULTU: begin
`ifdef FAST_MULT_EN
                  {hi_r, lo_r} <= fast_prod;
                  done_r       <= 1'b1;
`else
                  state   <= MUL;
                  busy_r  <= 1'b1;
                  cnt     <= '0;
                  is_div  <= 1'b0;
                  acc     <= {{WIDTH{1'b0}}, mag_b};
                  opnd    <= mag_a;
                  neg_res <= op_signed & (bus.rs_data_E[WIDTH-1] ^ bus.rt_data_E[WIDTH-1]);
                  neg_rem <= 1'b0;
`endif
                end
                MD_DIV, MD_DIVU: begin
                  state    <= DIV;
                  busy_r   <= 1'b1;
                  cnt      <= '0;
                  is_div   <= 1'b1;
                  acc      <= {{WIDTH{1'b0}}, mag_a};
                  opnd     <= mag_b;
                  div_zero <= (bus.rt_data_E == '0);
                  neg_res  <= op_signed & (bus.rs_data_E[WIDTH-1] ^ bus.rt_data_E[WIDTH-1]);
                  neg_rem  <= op_signed & bus.rs_data_E[WIDTH-1];
                end
                default: ;
              endcase
            end
          end
          MUL: begin
            acc <= mul_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
          end
          DIV: begin
            acc <= div_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
          end
          FIX: begin
            // Divide by zero leaves the raw dividend in HI (magnitude with its
            // sign restored) and all-ones in LO.
            if (is_div) begin
              hi_r <= rem_fix;
              lo_r <= div_zero ? '1 : quot_fix;
            end else begin
              {hi_r, lo_r} <= prod_fix;
            end
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Brief    : Self-checking bench for ex_muldiv_unit: directed vector table,
//            hand-written flush/reset/MT sequences and randomized operations
//            against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_muldiv_unit_if bus_if ();

  ex_muldiv_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the instruction semantics.
  function automatic void model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (op)
      MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      MD_MULT:  begin p = 64'(sa * sb);            h = p[63:32]; l = p[31:0]; end
      MD_DIVU: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      MD_DIV: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; l = 32'(q); h = 32'(r); end
      end
      default: ;
    endcase
  endfunction

  function automatic int exp_latency(input md_op_t op);
`ifdef FAST_MULT_EN
    if (op == MD_MULT || op == MD_MULTU) return 0;
`endif
    return 33;
  endfunction

  // Issue one mult/div and follow it to completion. Latency counts edges after
  // the edge that accepted start_E. With intrude set, an MTHI is presented
  // mid-operation and must be ignored.
  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit intrude, input string tag);
    int lat;
    int bc;
    bit stable;
    logic [31:0] h0;
    logic [31:0] l0;
    @(negedge clk);
    h0 = bus_if.hi;
    l0 = bus_if.lo;
    bus_if.start_E   = 1'b1;
    bus_if.md_op_E   = op;
    bus_if.rs_data_E = a;
    bus_if.rt_data_E = b;
    @(posedge clk);
    #1;
    bus_if.start_E = 1'b0;
    lat = 0;
    bc = 0;
    stable = 1'b1;
    while (!bus_if.done && lat < 60) begin
      if (bus_if.busy) bc++;
      if (bus_if.hi !== h0 || bus_if.lo !== l0) stable = 1'b0;
      if (intrude && lat == 4) begin
        bus_if.start_E   = 1'b1;
        bus_if.md_op_E   = MD_MTHI;
        bus_if.rs_data_E = 32'hDEAD_BEEF;
      end
      if (intrude && lat == 5) bus_if.start_E = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " done seen"}, 64'(bus_if.done), 64'd1);
    check({tag, " hi"}, 64'(bus_if.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus_if.lo), 64'(exp_lo));
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(op)));
    check({tag, " busy cycles"}, 64'(bc), 64'(exp_latency(op)));
    check({tag, " hi/lo held while busy"}, 64'(stable), 64'd1);
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, 64'(bus_if.done), 64'd0);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] a;
    logic [31:0] b;
    md_op_t      op;
    int          sel;
    int          w;

    checks = 0;
    errors = 0;

    vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{MD_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{MD_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{MD_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[6]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{MD_MULTU, 32'd6,         32'd7,         32'h0000_0000, 32'd42};
    vecs[10] = '{MD_DIVU,  32'd10,        32'd3,         32'd1,         32'd3};
    vecs[11] = '{MD_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

    rst_n            = 1'b0;
    bus_if.start_E   = 1'b0;
    bus_if.md_op_E   = MD_MULT;
    bus_if.rs_data_E = '0;
    bus_if.rt_data_E = '0;
    bus_if.flush     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(bus_if.hi), 64'd0);
    check("reset lo", 64'(bus_if.lo), 64'd0);
    check("reset busy", 64'(bus_if.busy), 64'd0);
    check("reset done", 64'(bus_if.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0,
             $sformatf("vec%0d", i));

    // start_E while busy is ignored
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, "div with intruding MTHI");

    // MTHI then MTLO back to back
    @(negedge clk);
    bus_if.start_E   = 1'b1;
    bus_if.md_op_E   = MD_MTHI;
    bus_if.rs_data_E = 32'h1234;
    @(posedge clk);
    #1;
    check("mthi busy", 64'(bus_if.busy), 64'd0);
    @(negedge clk);
    bus_if.md_op_E   = MD_MTLO;
    bus_if.rs_data_E = 32'h5678;
    @(posedge clk);
    #1;
    bus_if.start_E = 1'b0;
    check("mt hi", 64'(bus_if.hi), 64'h1234);
    check("mt lo", 64'(bus_if.lo), 64'h5678);
    check("mt busy", 64'(bus_if.busy), 64'd0);
    check("mt done", 64'(bus_if.done), 64'd0);

    // Flush in IDLE: no effect
    @(negedge clk);
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flush = 1'b0;
    check("idle flush busy", 64'(bus_if.busy), 64'd0);
    check("idle flush hi/lo", {32'(bus_if.hi), 32'(bus_if.lo)}, {32'h1234, 32'h5678});

    // Flush together with start_E: flush wins
    @(negedge clk);
    bus_if.flush     = 1'b1;
    bus_if.start_E   = 1'b1;
    bus_if.md_op_E   = MD_MTHI;
    bus_if.rs_data_E = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    check("flush+MTHI hi", 64'(bus_if.hi), 64'h1234);
    @(negedge clk);
    bus_if.md_op_E   = MD_DIVU;
    bus_if.rs_data_E = 32'd10;
    bus_if.rt_data_E = 32'd3;
    @(posedge clk);
    #1;
    bus_if.flush   = 1'b0;
    bus_if.start_E = 1'b0;
    check("flush+start busy", 64'(bus_if.busy), 64'd0);

    // Flush mid-divide
    @(negedge clk);
    bus_if.start_E   = 1'b1;
    bus_if.md_op_E   = MD_DIVU;
    bus_if.rs_data_E = 32'd10;
    bus_if.rt_data_E = 32'd3;
    @(posedge clk);
    #1;
    bus_if.start_E = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre-flush busy", 64'(bus_if.busy), 64'd1);
    @(negedge clk);
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flush = 1'b0;
    check("flush busy low", 64'(bus_if.busy), 64'd0);
    w = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus_if.done) w++;
      @(posedge clk);
      #1;
    end
    check("flush no done", 64'(w), 64'd0);
    check("flush hi/lo kept", {32'(bus_if.hi), 32'(bus_if.lo)}, {32'h1234, 32'h5678});
    run_op(MD_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, "divu after flush");

    // Reset mid-operation
    @(negedge clk);
    bus_if.start_E   = 1'b1;
`ifdef FAST_MULT_EN
    bus_if.md_op_E   = MD_DIVU;
`else
    bus_if.md_op_E   = MD_MULT;
`endif
    bus_if.rs_data_E = 32'hFFFF_FFF9;
    bus_if.rt_data_E = 32'd3;
    @(posedge clk);
    #1;
    bus_if.start_E = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-op reset hi", 64'(bus_if.hi), 64'd0);
    check("mid-op reset lo", 64'(bus_if.lo), 64'd0);
    check("mid-op reset busy", 64'(bus_if.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("after reset no result", {32'(bus_if.hi), 32'(bus_if.lo)}, 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op  = md_op_t'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) b = 32'hFFFF_FFFF;
      else if (sel == 2) b = 32'($urandom_range(1, 5));
      else               b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      model(op, a, b, eh, el);
      run_op(op, a, b, eh, el, 1'b0, $sformatf("rand%0d op%0d %h,%h", i, op, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
